// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - shared types, constants and helpers for the SPI register slave
package spi_reg_pkg;

  typedef enum logic [1:0] {
    CMD_RD   = 2'b00,
    CMD_RSV  = 2'b01,
    CMD_WR   = 2'b10,
    CMD_FAST = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    WAIT_DESEL,
    IDLE,
    CMD,
    DATA,
    CRC
  } fsm_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // CPHA=0 samples on the leading sclk edge, CPHA=1 on the trailing one
  function automatic logic spi_sample_on_lead(input logic [1:0] mode);
    return ~mode[0];
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchroniser with a registered rise/fall pulse stage
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // reset to the idle level of the line so no edge is reported after reset
  always_ff @(posedge clk) begin
    if (rst) sr <= {3{RST_VAL}};
    else     sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - oversampled SPI slave bridging a host to a register bank
// Define SPI_REG_CRC_EN to require a CRC-8 byte after every write word.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int REG_W    = 8,
  parameter int NUM_REGS = 8,
  parameter int SPI_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd_stb,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_vld,
  input  logic [7:0]        status,
  output logic [5:0]        fastcmd,
  output logic              fastcmd_vld,
  output logic              frame_err
);

  localparam logic [1:0] MODE        = SPI_MODE[1:0];
  localparam logic       CPOL        = MODE[1];
  localparam logic       LEAD_SAMPLE = spi_sample_on_lead(MODE);
  localparam int         CW          = $clog2(REG_W);

  logic sclk_s, sclk_rise, sclk_fall;
  logic nss_s, nss_rise, nss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_nss (
    .clk(clk), .rst(rst), .d(nss), .q(nss_s), .rise(nss_rise), .fall(nss_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic lead_edge, trail_edge, sample, shift;
  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;
  assign sample     = LEAD_SAMPLE ? lead_edge : trail_edge;
  assign shift      = LEAD_SAMPLE ? trail_edge : lead_edge;

  fsm_state_e        state;
  logic [CW-1:0]     cnt;
  logic [REG_W-1:0]  isr, osr, rd_buf, nx_isr;
  logic              load_pend, wr_mode, last_bit, in_frame;

  assign nx_isr   = {isr[REG_W-2:0], mosi_s};
  assign in_frame = (state == CMD) || (state == DATA) || (state == CRC);

  always_comb begin
    last_bit = 1'b0;
    case (state)
      CMD, CRC: last_bit = (cnt == CW'(7));
      DATA:     last_bit = (cnt == CW'(REG_W - 1));
      default:  last_bit = 1'b0;
    endcase
  end

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + 1'b1;
  endfunction

`ifdef SPI_REG_CRC_EN
  logic [7:0] crc;

  // covers the cmd byte plus every data byte since the last checked CRC
  always_ff @(posedge clk) begin
    if (rst || state == IDLE)
      crc <= '0;
    else if (sample && (state == CMD || state == DATA))
      crc <= crc8_step(crc, mosi_s);
    else if (sample && state == CRC && last_bit)
      crc <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_DESEL;
      cnt            <= '0;
      isr            <= '0;
      osr            <= '0;
      rd_buf         <= '0;
      load_pend      <= 1'b0;
      wr_mode        <= 1'b0;
      miso           <= 1'b0;
      miso_oe        <= 1'b0;
      reg_addr       <= '0;
      reg_rd_stb     <= 1'b0;
      reg_data_o     <= '0;
      reg_data_o_vld <= 1'b0;
      fastcmd        <= '0;
      fastcmd_vld    <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      reg_rd_stb     <= 1'b0;
      reg_data_o_vld <= 1'b0;
      fastcmd_vld    <= 1'b0;
      frame_err      <= 1'b0;
      miso_oe        <= ~nss_s;

      if (reg_rd_stb) begin
        rd_buf    <= reg_data_i;
        load_pend <= 1'b1;
      end
      if (reg_rd_stb || reg_data_o_vld)
        reg_addr <= addr_inc(reg_addr);

      if (shift && in_frame) begin
        if (load_pend) begin
          miso      <= rd_buf[REG_W-1];
          osr       <= {rd_buf[REG_W-2:0], 1'b0};
          load_pend <= 1'b0;
        end else begin
          miso <= osr[REG_W-1];
          osr  <= {osr[REG_W-2:0], 1'b0};
        end
      end

      case (state)
        WAIT_DESEL: begin
          miso <= 1'b0;
          if (nss_s) state <= IDLE;
        end
        IDLE: begin
          miso <= 1'b0;
          if (nss_fall) begin
            state     <= CMD;
            cnt       <= '0;
            load_pend <= 1'b0;
            // with CPHA=0 the master samples bit 7 before any shift edge
            if (LEAD_SAMPLE) begin
              miso <= status[7];
              osr  <= REG_W'({status[6:0], 1'b0}) << (REG_W - 8);
            end else begin
              osr <= REG_W'(status) << (REG_W - 8);
            end
          end
        end
        CMD: if (sample) begin
          isr <= nx_isr;
          if (last_bit) begin
            cnt      <= '0;
            reg_addr <= nx_isr[ADDR_W-1:0];
            case (cmd_e'(nx_isr[7:6]))
              CMD_RD: begin
                wr_mode    <= 1'b0;
                reg_rd_stb <= 1'b1;
                state      <= DATA;
              end
              CMD_WR: begin
                wr_mode <= 1'b1;
                state   <= DATA;
              end
              CMD_FAST: begin
                fastcmd     <= nx_isr[5:0];
                fastcmd_vld <= 1'b1;
                miso        <= 1'b0;
                state       <= WAIT_DESEL;
              end
              default: begin
                miso  <= 1'b0;
                state <= WAIT_DESEL;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: if (sample) begin
          isr <= nx_isr;
          if (last_bit) begin
            cnt <= '0;
            if (wr_mode) begin
              reg_data_o <= nx_isr;
`ifdef SPI_REG_CRC_EN
              state <= CRC;
`else
              reg_data_o_vld <= 1'b1;
`endif
            end else begin
              reg_rd_stb <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SPI_REG_CRC_EN
        CRC: if (sample) begin
          isr <= nx_isr;
          if (last_bit) begin
            cnt <= '0;
            if (nx_isr[7:0] == crc) begin
              reg_data_o_vld <= 1'b1;
              state          <= DATA;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_DESEL;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        default: state <= WAIT_DESEL;
      endcase

      // a word finishing on the same clk as deselect still counts as complete
      if (nss_rise && in_frame) begin
        state     <= IDLE;
        miso      <= 1'b0;
        load_pend <= 1'b0;
        if (!(sample && last_bit) && (state == CMD || state == CRC || cnt != '0))
          frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench: one DUT per SPI mode, instance 0 with 16-bit registers
module tb_spi_reg_bank;

  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sclk_r = 4'b1100;
  logic [3:0] nss_r  = 4'b1111;
  logic [3:0] mosi_r = 4'b0000;
  logic [7:0] status = 8'h5A;

  logic [3:0]       miso_w, oe_w, rstb_w, wvld_w, fvld_w, fe_w;
  logic [3:0][2:0]  ra_w;
  logic [3:0][15:0] rdo_w;
  logic [3:0][5:0]  fc_w;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt [4] = '{0, 0, 0, 0};

  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_fast[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RW = (g == 0) ? 16 : 8;
    logic [RW-1:0] rdo, rdi;
    assign rdi = (ra_w[g] == 3'd2) ? RW'(16'h1234) : RW'(16'hC0DE);
    spi_reg_bank #(.ADDR_W(3), .REG_W(RW), .NUM_REGS(8), .SPI_MODE(g)) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk_r[g]), .nss(nss_r[g]), .mosi(mosi_r[g]),
      .miso(miso_w[g]), .miso_oe(oe_w[g]), .reg_addr(ra_w[g]), .reg_rd_stb(rstb_w[g]),
      .reg_data_i(rdi), .reg_data_o(rdo), .reg_data_o_vld(wvld_w[g]), .status(status),
      .fastcmd(fc_w[g]), .fastcmd_vld(fvld_w[g]), .frame_err(fe_w[g])
    );
    assign rdo_w[g] = 16'(rdo);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 4; g++) begin
        logic [31:0] e;
        if (wvld_w[g]) begin
          e = 32'hFFFF_FFFF;
          if (exp_wr.size() != 0) e = exp_wr.pop_front();
          check("wr_strobe", {8'(g), 5'd0, ra_w[g], rdo_w[g]}, e);
        end
        if (rstb_w[g]) begin
          e = 32'hFFFF_FFFF;
          if (exp_rd.size() != 0) e = exp_rd.pop_front();
          check("rd_strobe", {8'(g), 21'd0, ra_w[g]}, e);
        end
        if (fvld_w[g]) begin
          e = 32'hFFFF_FFFF;
          if (exp_fast.size() != 0) e = exp_fast.pop_front();
          check("fastcmd", {8'(g), 18'd0, fc_w[g]}, e);
        end
        if (fe_w[g]) fe_cnt[g]++;
      end
    end
  end

  task automatic spi_xfer(input int g, input logic [63:0] tx, input int n, output logic [63:0] rx);
    logic cpol, cpha;
    cpol = g[1];
    cpha = g[0];
    rx = '0;
    @(negedge clk);
    sclk_r[g] = cpol;
    nss_r[g]  = 1'b0;
    repeat (2 * H) @(negedge clk);
    check("miso_oe", 32'(oe_w[g]), 32'd1);
    for (int i = n - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi_r[g] = tx[i];
        repeat (H) @(negedge clk);
        rx[i] = miso_w[g];
        sclk_r[g] = ~cpol;
        repeat (H) @(negedge clk);
        sclk_r[g] = cpol;
      end else begin
        sclk_r[g] = ~cpol;
        mosi_r[g] = tx[i];
        repeat (H) @(negedge clk);
        rx[i] = miso_w[g];
        sclk_r[g] = cpol;
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
    nss_r[g] = 1'b1;
    repeat (4 * H) @(negedge clk);
  endtask

  task automatic wr_frame(input int g, input logic [7:0] cmd, input logic [23:0] d, input int nw);
    logic [63:0] tx, rx;
    logic [7:0]  c, b;
    int n;
    tx = 64'(cmd);
    n  = 8;
    c  = crc8_byte(8'h00, cmd);
    for (int w = nw - 1; w >= 0; w--) begin
      b  = d[w*8 +: 8];
      tx = {tx[55:0], b};
      n  = n + 8;
`ifdef SPI_REG_CRC_EN
      c  = crc8_byte(c, b);
      tx = {tx[55:0], c};
      n  = n + 8;
      c  = 8'h00;
`endif
    end
    spi_xfer(g, tx, n, rx);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rx;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_addr", 32'(ra_w[g]), 32'd0);
      check("rst_outs", {24'd0, miso_w[g], oe_w[g], rstb_w[g], wvld_w[g], fvld_w[g], fe_w[g], 2'b00}, 32'd0);
      check("rst_data", 32'(rdo_w[g]), 32'd0);
    end

    // mode 1: single write to address 3
    exp_wr.push_back({8'd1, 8'd3, 16'h00A5});
    wr_frame(1, 8'h83, 24'h0000A5, 1);
    check("wr_addr_after", 32'(ra_w[1]), 32'd4);
    check("wr_no_err", 32'(fe_cnt[1]), 32'd0);

    // mode 0, 16-bit: status then register 2, a prefetch strobe at the word boundary
    exp_rd.push_back({8'd0, 24'd2});
    exp_rd.push_back({8'd0, 24'd3});
    spi_xfer(0, 64'h0000_0000_0002_0000, 24, rx);
    check("rd_miso", 32'(rx[23:0]), 32'h005A_1234);
    check("rd_addr_after", 32'(ra_w[0]), 32'd4);
    check("rd_no_err", 32'(fe_cnt[0]), 32'd0);

    // mode 3: burst write wrapping 6,7,0
    exp_wr.push_back({8'd3, 8'd6, 16'h0011});
    exp_wr.push_back({8'd3, 8'd7, 16'h0022});
    exp_wr.push_back({8'd3, 8'd0, 16'h0033});
    wr_frame(3, 8'h86, 24'h112233, 3);
    check("burst_addr_after", 32'(ra_w[3]), 32'd1);

    // mode 2: fast command, trailing bits ignored
    exp_fast.push_back({8'd2, 24'h09});
    spi_xfer(2, 64'h0000_0000_00C9_85AA, 24, rx);
    check("fast_status", 32'(rx[23:16]), 32'h5A);
    check("fast_addr", 32'(ra_w[2]), 32'd1);
    check("fast_no_err", 32'(fe_cnt[2]), 32'd0);

    // mode 1: truncated write, then a normal frame
    spi_xfer(1, 64'(13'b1000_0101_10110), 13, rx);
    check("partial_err", 32'(fe_cnt[1]), 32'd1);
    exp_wr.push_back({8'd1, 8'd5, 16'h0077});
    wr_frame(1, 8'h85, 24'h000077, 1);
    check("recover_err", 32'(fe_cnt[1]), 32'd1);

    // reserved command: silent, no error
    spi_xfer(1, 64'h45FF, 16, rx);
    check("rsv_no_err", 32'(fe_cnt[1]), 32'd1);

`ifdef SPI_REG_CRC_EN
    exp_wr.push_back({8'd1, 8'd1, 16'h003C});
    wr_frame(1, 8'h81, 24'h00003C, 1);
    check("crc_ok_err", 32'(fe_cnt[1]), 32'd1);
    spi_xfer(1, {40'd0, 8'h81, 8'h3C, crc8_byte(crc8_byte(8'h00, 8'h81), 8'h3C) ^ 8'h01}, 24, rx);
    check("crc_bad_err", 32'(fe_cnt[1]), 32'd2);
`endif

    repeat (10) @(negedge clk);
    check("wr_left", 32'(exp_wr.size()), 32'd0);
    check("rd_left", 32'(exp_rd.size()), 32'd0);
    check("fast_left", 32'(exp_fast.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
